// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file debug dumper: FSM state encoding
// and the default register-file geometry it is paired with.
package rf_dump_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_dump.sv
// Sweeps an optionally wrapping address range over the register file debug
// read port and streams one {address, data} record per register.
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    input  logic          abort,
    output logic [AW-1:0] ra_debug,
    input  logic [DW-1:0] rd_debug,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    o_dbg_state
);

    // Output stream: a record transfers on a cycle where out_valid && out_ready.
    // out_valid stays high with out_addr/out_data stable until that happens; the
    // only exception is abort (or reset), which retracts the record unsent.

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_last;
    logic [AW-1:0]   r_out_addr;
    logic [DW-1:0]   r_out_data;
    logic            w_handshake;
    logic            w_at_last;

    assign w_handshake = (r_state == ST_HOLD) && out_ready;
    assign w_at_last   = (r_addr == r_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks every transition outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_handshake) begin
                    w_state_nxt = w_at_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address counter and record capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_last     <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr <= first_addr;
                        r_last <= last_addr;
                    end
                end
                ST_READ: begin
                    if (!abort) begin
                        r_out_data <= rd_debug;
                        r_out_addr <= r_addr;
                    end
                end
                ST_HOLD: begin
                    // Increment wraps modulo 2^AW, which gives the wrapping sweep for free
                    if (!abort && w_handshake && !w_at_last) begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid   = (r_state == ST_HOLD);
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        ra_debug    = r_addr;
        out_addr    = r_out_addr;
        out_data    = r_out_data;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump with a behavioural register file that forwards
// same-cycle writes onto the debug read port.
module tb_rf_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        abort;
    logic [4:0]  ra_debug;
    logic [31:0] rd_debug;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rf [32];

    int total;
    int passed;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rf_dump dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .abort       (abort),
        .ra_debug    (ra_debug),
        .rd_debug    (rd_debug),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end
    assign rd_debug = (wr_en && wr_addr == ra_debug) ? wr_data : rf[ra_debug];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One sweep f..l. Hooks: stall out_ready for stall_n cycles at record
    // stall_at, forward a write to fwd_at during its READ, abort at record
    // abort_at, pulse a foreign start while holding record bstart_at.
    task automatic sweep(input int f, input int l, input int stall_at, input int stall_n,
                         input int fwd_at, input int abort_at, input int bstart_at);
        int  n, n_rec, stalls, exp_len, last_hs, ea;
        bit  fin, done_seen, aborted;
        logic [31:0] ed;
        exp_len   = ((l - f) & 31) + 1;
        n = 0; n_rec = 0; stalls = 0; last_hs = -10;
        fin = 0; done_seen = 0; aborted = 0;
        start = 1'b1; first_addr = 5'(f); last_addr = 5'(l); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1;
        check("busy_after_start", busy, 1);
        check("no_valid_in_read", out_valid, 0);
        while (!fin && n < 300) begin
            @(negedge clk);
            n++;
            wr_en = 1'b0; abort = 1'b0; out_ready = 1'b1; start = 1'b0;
            if (aborted) begin
                check("abort_valid_low", out_valid, 0);
                check("abort_busy_low", busy, 0);
                check("abort_no_done", done, 0);
                fin = 1;
            end else if (done_seen) begin
                check("idle_after_done", busy, 0);
                check("done_one_cycle", done, 0);
                fin = 1;
            end else if (done) begin
                check("done_timing", n, last_hs + 1);
                check("record_count", n_rec, exp_len);
                done_seen = 1;
            end else if (out_valid) begin
                ea = (f + n_rec) % 32;
                ed = (ea == fwd_at) ? 32'hDEADBEEF : 32'(ea) * 32'h01010101;
                check("rec_addr", out_addr, ea);
                check("rec_data", out_data, ed);
                check("rec_timing", n, 2 + 2 * n_rec + stalls);
                if (ea == abort_at) begin
                    abort = 1'b1;
                    aborted = 1;
                end else if (ea == stall_at && stalls < stall_n) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    if (ea == bstart_at) begin
                        start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
                    end
                    n_rec++;
                    last_hs = n;
                end
            end else if (dbg_state == 2'd1 && int'(ra_debug) == fwd_at) begin
                wr_en = 1'b1; wr_addr = 5'(fwd_at); wr_data = 32'hDEADBEEF;
            end
        end
        check("sweep_finished", fin, 1);
        wr_en = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        int n;
        total = 0; passed = 0;
        rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        abort = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Preload reg i = i * 0x01010101 while held in reset
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("rst_state", dbg_state, 0);
        check("rst_ra_debug", ra_debug, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full sweep, wrap sweep, backpressure
        sweep(0, 31, -1, 0, -1, -1, -1);
        sweep(30, 1, -1, 0, -1, -1, -1);
        sweep(5, 7, 6, 3, -1, -1, -1);

        // Forwarded write lands in record 9, then restore reg 9
        sweep(8, 10, -1, 0, 9, -1, -1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h09090909;
        @(negedge clk);
        wr_en = 1'b0;

        // Abort together with a handshake at record 3, then single-record sweep
        sweep(0, 31, -1, 0, -1, 3, -1);
        sweep(4, 4, -1, 0, -1, -1, -1);

        // start while busy is ignored; range stays 10..12
        sweep(10, 12, -1, 0, -1, -1, 11);

        // Reset while holding a record
        start = 1'b1; first_addr = 5'd3; last_addr = 5'd5; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", out_valid, 1);
        check("hold_data", out_data, 32'h03030303);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_addr", out_addr, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ra", ra_debug, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
